// File: rtl/lutram_cmd_responder.sv
// Responder for the LUTRAM/PSRAM stress-test command protocol: parses host read/write
// commands from an RX byte stream, drives a single-port RAM, returns read data as TX bytes.
module lutram_cmd_responder #(
  parameter int ADDR_W      = 8,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wdat,
  output logic              ram_we,
  input  logic [15:0]       ram_rdat,
  output logic              busy,
  output logic              err_opcode,
  output logic              err_timeout
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_TX_HI   = 3'd5;
  localparam logic [2:0] S_TX_LO   = 3'd6;

  localparam int TO_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int WAIT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT_CYC);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT);

  logic [2:0]        state;
  logic              is_write;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] addr_sr;
  logic [ADDR_W-1:0] addr_next;
  logic [7:0]        data_hi;
  logic [7:0]        rdat_lo;
  logic [WAIT_W-1:0] wait_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              rx_hs;
  logic              to_hit;

  // rx_ready is gated by rst so it reads 0 while reset is held, 1 in the first IDLE cycle after
  assign rx_ready  = ~rst & ((state == S_IDLE) | (state == S_ADDR) | (state == S_DATA));
  assign rx_hs     = rx_valid & rx_ready;
  assign busy      = (state != S_IDLE);
  assign ram_we    = (state == S_WRITE);
  assign to_hit    = (TIMEOUT_CYC != 0) && (to_cnt == TO_MAX);
  // Only the low ADDR_W bits of the 32-bit address survive the shift
  assign addr_next = ADDR_W'({addr_sr, rx_data});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      is_write    <= 1'b0;
      byte_cnt    <= '0;
      addr_sr     <= '0;
      data_hi     <= '0;
      rdat_lo     <= '0;
      wait_cnt    <= '0;
      to_cnt      <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      ram_addr    <= '0;
      ram_wdat    <= '0;
      err_opcode  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_opcode  <= 1'b0;
      err_timeout <= 1'b0;

      // A byte arriving in the same cycle the limit is reached takes priority over the abort
      if (state == S_ADDR || state == S_DATA) begin
        if (rx_hs) begin
          to_cnt <= '0;
        end else if (to_hit) begin
          state       <= S_IDLE;
          err_timeout <= 1'b1;
          to_cnt      <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (rx_hs) begin
            if (rx_data == 8'h00 || rx_data == 8'h01) begin
              is_write <= rx_data[0];
              byte_cnt <= '0;
              to_cnt   <= '0;
              state    <= S_ADDR;
            end else begin
              err_opcode <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (rx_hs) begin
            addr_sr  <= addr_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (is_write) begin
                state <= S_DATA;
              end else begin
                ram_addr <= addr_next;
                wait_cnt <= '0;
                state    <= S_RD_WAIT;
              end
            end
          end
        end
        S_DATA: begin
          if (rx_hs) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd0) begin
              data_hi <= rx_data;
            end else begin
              ram_wdat <= {data_hi, rx_data};
              ram_addr <= addr_sr;
              state    <= S_WRITE;
            end
          end
        end
        S_WRITE: state <= S_IDLE;
        S_RD_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            tx_data  <= ram_rdat[15:8];
            rdat_lo  <= ram_rdat[7:0];
            tx_valid <= 1'b1;
            state    <= S_TX_HI;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_TX_HI: begin
          if (tx_ready) begin
            tx_data <= rdat_lo;
            state   <= S_TX_LO;
          end
        end
        S_TX_LO: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lutram_cmd_responder.sv
// Self-checking bench for lutram_cmd_responder: directed protocol sequences, a vector
// table and randomized commands checked against an array model of the memory.
module tb_lutram_cmd_responder;

  localparam int ADDR_W      = 8;
  localparam int RD_LAT      = 1;
  localparam int TIMEOUT_CYC = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_wdat;
  logic              ram_we;
  logic [15:0]       ram_rdat;
  logic              busy;
  logic              err_opcode;
  logic              err_timeout;

  always #5 clk = ~clk;

  lutram_cmd_responder #(
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ram_addr(ram_addr), .ram_wdat(ram_wdat), .ram_we(ram_we), .ram_rdat(ram_rdat),
    .busy(busy), .err_opcode(err_opcode), .err_timeout(err_timeout)
  );

  // Memory under test: synchronous read, one clock of latency
  logic [15:0] ram [0:255];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdat;
    ram_rdat <= ram[ram_addr];
  end

  int we_cnt = 0, eop_cnt = 0, eto_cnt = 0;
  always @(negedge clk) begin
    if (ram_we) we_cnt++;
    if (err_opcode) eop_cnt++;
    if (err_timeout) eto_cnt++;
  end

  int checks = 0, errors = 0;

  // Reference model: what the memory should hold, by truncated address
  logic [15:0] exp_mem [256];
  int unsigned written_q[$];

  function automatic int unsigned trunc_addr(input logic [31:0] a);
    return a % (32'd1 << ADDR_W);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [15:0] d);
    exp_mem[trunc_addr(a)] = d;
    written_q.push_back(trunc_addr(a));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) tick();
    n = 0;
    while (!rx_ready && n < 300) begin tick(); n++; end
    if (!rx_ready) check("rx_ready_wait", 32'(rx_ready), 32'd1);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input bit wr, input logic [31:0] a, input logic [15:0] d,
                          input int gap_min, input int gap_max);
    logic [7:0] b [7];
    int nb;
    b[0] = wr ? 8'h01 : 8'h00;
    b[1] = a[31:24]; b[2] = a[23:16]; b[3] = a[15:8]; b[4] = a[7:0];
    b[5] = d[15:8];  b[6] = d[7:0];
    nb = wr ? 7 : 5;
    for (int i = 0; i < nb; i++)
      send_byte(b[i], (i == 0) ? 0 : int'($urandom_range(gap_max, gap_min)));
  endtask

  task automatic recv_resp(output logic [15:0] v, input int max_stall);
    logic [7:0] b [2];
    int n, stall;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!tx_valid && n < 300) begin tick(); n++; end
      if (!tx_valid) check("tx_valid_wait", 32'(tx_valid), 32'd1);
      stall = $urandom_range(max_stall, 0);
      repeat (stall) tick();
      b[k]     = tx_data;
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
    end
    check("tx_valid_drop", 32'(tx_valid), 32'd0);
    v = {b[0], b[1]};
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [15:0] wdat;
    logic [7:0]  exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] resp;
    logic [31:0] a;
    logic [15:0] d;
    int base, n, kind;

    tbl[0] = '{1'b1, 32'hFF00_01FF, 16'hABCD, 8'hFF, 16'hABCD};
    tbl[1] = '{1'b1, 32'h1234_5677, 16'h0001, 8'h77, 16'h0001};
    tbl[2] = '{1'b1, 32'h0000_0100, 16'h5A5A, 8'h00, 16'h5A5A};
    tbl[3] = '{1'b0, 32'hFF00_01FF, 16'h0000, 8'hFF, 16'hABCD};
    tbl[4] = '{1'b0, 32'hABCD_EF77, 16'h0000, 8'h77, 16'h0001};
    tbl[5] = '{1'b0, 32'h0000_0000, 16'h0000, 8'h00, 16'h5A5A};
    tbl[6] = '{1'b0, 32'h0000_002A, 16'h0000, 8'h2A, 16'h1234};

    rst = 1'b1; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
    tick(); tick();
    check("rst_rx_ready", 32'(rx_ready), 0);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_outputs", {tx_data, ram_addr, ram_wdat}, 0);
    check("rst_flags", {29'd0, ram_we, busy, err_opcode | err_timeout}, 0);
    rst = 1'b0;
    #1 check("rx_ready_after_rst", 32'(rx_ready), 1);
    tick();

    // Directed write: ram_we exactly one cycle after the last byte
    base = we_cnt;
    send_cmd(1'b1, 32'h0000_002A, 16'h1234, 0, 0);
    model_write(32'h0000_002A, 16'h1234);
    check("wr_we", 32'(ram_we), 1);
    check("wr_addr", 32'(ram_addr), 32'h2A);
    check("wr_wdat", 32'(ram_wdat), 32'h1234);
    tick();
    check("wr_we_fall", 32'(ram_we), 0);
    check("wr_busy_fall", 32'(busy), 0);
    check("wr_rx_ready_n2", 32'(rx_ready), 1);
    tick();
    check("wr_we_count", we_cnt - base, 1);

    // Directed read: tx_valid first high 3 cycles after the last address byte
    send_cmd(1'b0, 32'h0000_002A, 16'h0, 0, 0);
    check("rd_addr", 32'(ram_addr), 32'h2A);
    check("rd_lat_c1", 32'(tx_valid), 0);
    tick();
    check("rd_lat_c2", 32'(tx_valid), 0);
    tick();
    check("rd_lat_c3", 32'(tx_valid), 1);
    check("rd_hi", 32'(tx_data), exp_mem[8'h2A][15:8]);
    tx_ready = 1'b1;
    tick();
    check("rd_lo_valid", 32'(tx_valid), 1);
    check("rd_lo", 32'(tx_data), exp_mem[8'h2A][7:0]);
    tick();
    tx_ready = 1'b0;
    check("rd_done", {30'd0, tx_valid, busy}, 0);

    // Backpressure: 50 stalled cycles with junk offered on RX
    base = eop_cnt;
    send_cmd(1'b0, 32'h0000_002A, 16'h0, 0, 0);
    n = 0;
    while (!tx_valid && n < 50) begin tick(); n++; end
    rx_data = 8'h07; rx_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (!(tx_valid === 1'b1 && tx_data === 8'h12 && rx_ready === 1'b0)) n++;
      tick();
    end
    check("stall_hold_bad_cycles", n, 0);
    rx_valid = 1'b0;
    recv_resp(resp, 0);
    check("stall_resp", 32'(resp), 32'h1234);
    check("stall_no_rx", eop_cnt - base, 0);

    // Bad opcode then a valid write
    base = we_cnt;
    send_byte(8'h07, 0);
    check("badop_pulse", 32'(err_opcode), 1);
    check("badop_busy", 32'(busy), 0);
    tick();
    check("badop_pulse_fall", 32'(err_opcode), 0);
    check("badop_no_we", we_cnt - base, 0);
    send_cmd(1'b1, 32'h0000_0055, 16'hBEEF, 0, 0);
    model_write(32'h0000_0055, 16'hBEEF);
    check("badop_wr", {7'd0, ram_we, 8'(ram_addr), ram_wdat}, {8'd1, 8'h55, 16'hBEEF});
    tick();

    // Inter-byte timeout abort
    base = we_cnt;
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    n = 0;
    while (!err_timeout && n < 200) begin tick(); n++; end
    check("to_pulse", 32'(err_timeout), 1);
    check("to_window", 32'(n >= TIMEOUT_CYC && n <= TIMEOUT_CYC + 2), 1);
    check("to_busy", 32'(busy), 0);
    tick();
    check("to_pulse_fall", 32'(err_timeout), 0);
    check("to_no_we", we_cnt - base, 0);
    send_cmd(1'b0, 32'h0000_002A, 16'h0, 0, 0);
    recv_resp(resp, 2);
    check("to_then_read", 32'(resp), 32'(exp_mem[8'h2A]));

    // Gaps just under the limit must not abort
    base = eto_cnt;
    send_cmd(1'b1, 32'h0000_003C, 16'h0F0F, TIMEOUT_CYC - 5, TIMEOUT_CYC - 5);
    model_write(32'h0000_003C, 16'h0F0F);
    check("gap_wr", {7'd0, ram_we, 8'(ram_addr), ram_wdat}, {8'd1, 8'h3C, 16'h0F0F});
    check("gap_no_timeout", eto_cnt - base, 0);
    tick();

    // Reset after the third byte of a write
    base = we_cnt;
    send_byte(8'h01, 0); send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_flags", {28'd0, rx_ready, tx_valid, ram_we, busy}, 0);
    check("mid_rst_regs", {tx_data, ram_addr, ram_wdat}, 0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    check("mid_rst_no_we", we_cnt - base, 0);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].wr) begin
        send_cmd(1'b1, tbl[i].addr, tbl[i].wdat, 0, 1);
        model_write(tbl[i].addr, tbl[i].wdat);
        check($sformatf("tbl%0d_wr", i), {7'd0, ram_we, 8'(ram_addr), ram_wdat},
              {8'd1, tbl[i].exp_addr, tbl[i].exp_data});
        tick();
      end else begin
        send_cmd(1'b0, tbl[i].addr, 16'h0, 0, 1);
        recv_resp(resp, 2);
        check($sformatf("tbl%0d_rd", i), {8'(ram_addr), resp}, {tbl[i].exp_addr, tbl[i].exp_data});
      end
    end

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(9, 0);
      if (kind < 5) begin
        a = $urandom();
        d = 16'($urandom());
        send_cmd(1'b1, a, d, 0, 3);
        model_write(a, d);
        check($sformatf("rnd%0d_wr", i), {7'd0, ram_we, 8'(ram_addr), ram_wdat},
              {8'd1, 8'(trunc_addr(a)), d});
        tick();
      end else if (kind < 9) begin
        a = ($urandom() & 32'hFFFF_FF00) | written_q[$urandom_range(written_q.size() - 1, 0)];
        send_cmd(1'b0, a, 16'h0, 0, 3);
        recv_resp(resp, 3);
        check($sformatf("rnd%0d_rd", i), 32'(resp), 32'(exp_mem[trunc_addr(a)]));
      end else begin
        base = eop_cnt;
        send_byte(8'($urandom_range(255, 2)), 0);
        tick();
        check($sformatf("rnd%0d_badop", i), eop_cnt - base, 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
